// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding,
// default operand width and the product-width helper.
package mul_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned PROD_W    = 2 * DEF_WIDTH;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } mul_state_e;

   // Product width for a given operand width.
   function automatic int unsigned prod_w(input int unsigned width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-and-add iteration, purely combinational.
// Kept standalone so a radix-4 variant can chain two instances per cycle.
module mul_step
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic [2*WIDTH-1:0] acc_next,
   output logic [2*WIDTH-1:0] mcand_next,
   output logic [WIDTH-1:0]   mplier_next
);

   // Add the aligned multiplicand when the current multiplier bit is set, then realign.
   always_comb begin
      acc_next = acc;
      if (mplier[0]) begin
         acc_next = acc + mcand;
      end
      mcand_next  = mcand << 1;
      mplier_next = mplier >> 1;
   end

endmodule

// File: rtl/multiplier_core.sv
// Sequential radix-2 multiplier: product = multiplicand * multiplier + addend (unsigned).
// Optional MULTIPLIER_CORE_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero. Default build has a fixed WIDTH-cycle RUN phase.
module multiplier_core
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_calc,
   input  logic [WIDTH-1:0]           multiplicand,
   input  logic [WIDTH-1:0]           multiplier,
   input  logic [WIDTH-1:0]           addend,
   output logic                       busy,
   output logic                       done_calc,
   output logic [prod_w(WIDTH)-1:0]   product,
   output logic                       overflow
);

   localparam int unsigned PW    = prod_w(WIDTH);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   mul_state_e        state_q, state_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PW-1:0]     product_q, product_d;
   logic              overflow_q, overflow_d;

   logic [PW-1:0]     acc_step;
   logic [PW-1:0]     mcand_step;
   logic [WIDTH-1:0]  mplier_step;
   logic              last_iter;

   mul_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc         (acc_q),
      .mcand       (mcand_q),
      .mplier      (mplier_q),
      .acc_next    (acc_step),
      .mcand_next  (mcand_step),
      .mplier_next (mplier_step)
   );

`ifdef MULTIPLIER_CORE_EARLY_TERM_EN
   // No set bits left means further iterations cannot change acc.
   assign last_iter = (count_q == LAST_CNT) || (mplier_step == '0);
`else
   assign last_iter = (count_q == LAST_CNT);
`endif

   // Next-state and datapath update for IDLE -> RUN -> DONE -> IDLE.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      count_d    = count_q;
      product_d  = product_q;
      overflow_d = overflow_q;
      case (state_q)
         StIdle: begin
            if (start_calc) begin
               acc_d    = PW'(addend);
               mcand_d  = PW'(multiplicand);
               mplier_d = multiplier;
               count_d  = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            acc_d    = acc_step;
            mcand_d  = mcand_step;
            mplier_d = mplier_step;
            count_d  = count_q + CNT_W'(1);
            if (last_iter) begin
               product_d  = acc_step;
               overflow_d = |acc_step[PW-1:WIDTH];
               state_d    = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset aborts any calculation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         count_q    <= '0;
         product_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         count_q    <= count_d;
         product_q  <= product_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy      = (state_q != StIdle);
   assign done_calc = (state_q == StDone);
   assign product   = product_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_multiplier_core.sv
// Self-checking bench for multiplier_core (WIDTH=32) against a plain-arithmetic model.
// Build with MULTIPLIER_CORE_EARLY_TERM_EN defined to check the early-termination latency.
module tb_multiplier_core;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_calc;
   logic [W-1:0]  multiplicand;
   logic [W-1:0]  multiplier;
   logic [W-1:0]  addend;
   logic          busy;
   logic          done_calc;
   logic [2*W-1:0] product;
   logic          overflow;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   multiplier_core #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_calc   (start_calc),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .busy         (busy),
      .done_calc    (done_calc),
      .product      (product),
      .overflow     (overflow)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
      longint unsigned r;
      r = longint'(a) * longint'(b) + longint'(c);
      return r;
   endfunction

   // Start edge to done cycle, counted in cycles.
   function automatic int exp_lat(input logic [31:0] b);
`ifdef MULTIPLIER_CORE_EARLY_TERM_EN
      int hi;
      hi = -1;
      for (int i = 0; i < 32; i++) if (b[i]) hi = i;
      return (hi < 0) ? 2 : hi + 2;
`else
      return W + 1;
`endif
   endfunction

   // Counts falling edges after the start edge until done_calc is seen, bounded.
   task automatic wait_done(output int k, output bit seen);
      k = 0;
      seen = 1'b0;
      while (!seen && k < int'(W) + 10) begin
         @(negedge clk);
         k++;
         if (done_calc) seen = 1'b1;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
      logic [63:0] e;
      int k;
      bit seen;
      e = model(a, b, c);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      addend       = c;
      start_calc   = 1'b1;
      @(posedge clk);
      #1;
      start_calc   = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      addend       = $urandom;
      wait_done(k, seen);
      chk({tag, ":done_seen"}, 64'(seen), 64'd1);
      chk({tag, ":latency"}, 64'(k), 64'(exp_lat(b)));
      chk({tag, ":product"}, product, e);
      chk({tag, ":overflow"}, 64'(overflow), 64'(e[63:32] != 0));
      chk({tag, ":busy_in_done"}, 64'(busy), 64'd1);
      @(negedge clk);
      chk({tag, ":done_one_cycle"}, 64'(done_calc), 64'd0);
      chk({tag, ":idle_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int k;
      int pulses;
      bit seen;
      logic [31:0] n, d, q, r;
      logic [31:0] a2, b2, c2;

      rst          = 1'b1;
      start_calc   = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      addend       = '0;
      #1;
      chk("reset:busy", 64'(busy), 64'd0);
      chk("reset:done", 64'(done_calc), 64'd0);
      chk("reset:product", product, 64'd0);
      chk("reset:overflow", 64'(overflow), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("basic", 32'd7, 32'd6, 32'd2);
      chk("basic:44", product, 64'd44);
      run_op("roundtrip", 32'd7, 32'd14, 32'd2);
      chk("roundtrip:100", product, 64'd100);
      run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("max:value", product, 64'hFFFF_FFFF_0000_0000);
      chk("max:ovf", 64'(overflow), 64'd1);
      run_op("mplier0", 32'hDEAD_BEEF, 32'd0, 32'd5);
      chk("mplier0:5", product, 64'd5);
      run_op("mcand0", 32'd0, 32'h8000_0001, 32'd9);
      run_op("early3", 32'd5, 32'd3, 32'd0);
      chk("early3:15", product, 64'd15);
      run_op("topbit", 32'd3, 32'h8000_0000, 32'd1);

      // start_calc held high throughout: only the first operands count, and the
      // next accept lands on the edge closing the IDLE cycle after done.
      a2 = 32'd1234;
      b2 = 32'd5678;
      c2 = 32'd99;
      @(negedge clk);
      multiplicand = 32'd11;
      multiplier   = 32'd13;
      addend       = 32'd17;
      start_calc   = 1'b1;
      @(posedge clk);
      k = 0;
      seen = 1'b0;
      while (!seen && k < int'(W) + 10) begin
         @(negedge clk);
         k++;
         if (done_calc) seen = 1'b1;
         else begin
            multiplicand = $urandom;
            multiplier   = $urandom;
            addend       = $urandom;
         end
      end
      chk("hold:done_seen", 64'(seen), 64'd1);
      chk("hold:latency", 64'(k), 64'(exp_lat(32'd13)));
      chk("hold:first_ops", product, 64'd160);
      multiplicand = a2;
      multiplier   = b2;
      addend       = c2;
      @(negedge clk);
      chk("hold:idle_gap_busy", 64'(busy), 64'd0);
      chk("hold:idle_gap_done", 64'(done_calc), 64'd0);
      @(posedge clk);
      #1;
      start_calc   = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      wait_done(k, seen);
      chk("hold2:done_seen", 64'(seen), 64'd1);
      chk("hold2:latency", 64'(k), 64'(exp_lat(b2)));
      chk("hold2:product", product, model(a2, b2, c2));

      // Reset during RUN must abort with no pulse afterwards.
      @(negedge clk);
      multiplicand = 32'hFFFF_0000;
      multiplier   = 32'hFFFF_FFFF;
      addend       = 32'd3;
      start_calc   = 1'b1;
      @(posedge clk);
      #1;
      start_calc = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rstmid:busy", 64'(busy), 64'd0);
      chk("rstmid:product", product, 64'd0);
      chk("rstmid:overflow", 64'(overflow), 64'd0);
      chk("rstmid:done", 64'(done_calc), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (int'(W) + 8) begin
         @(negedge clk);
         if (done_calc || busy) pulses++;
      end
      chk("rstmid:no_activity", 64'(pulses), 64'd0);
      run_op("after_rst", 32'd100, 32'd200, 32'd300);

      // Random full-range operands.
      for (int i = 0; i < 50; i++) begin
         run_op("rand", $urandom, $urandom, $urandom);
      end

      // Divider round trip: (denominator, quotient, remainder) rebuilds the numerator.
      for (int i = 0; i < 1000; i++) begin
         n = $urandom;
         d = ($urandom % 2 == 0) ? 32'($urandom_range(255, 1)) : $urandom;
         if (d == 0) d = 32'd1;
         q = n / d;
         r = n % d;
         run_op("divrt", d, q, r);
         chk("divrt:numerator", product, {32'd0, n});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
